// File: rtl/linear_pkg.sv
// Shared types and helpers for the parallel fully connected layer.
//   state_t    : control FSM states
//   act_mode_t : runtime activation select
//   acc_width  : accumulator width needed for a dot product of n terms
//   idx_width  : index width that never collapses to zero bits
//   saturate   : clamp to the signed range of a given width
//   activate   : identity / ReLU / ReLU6 (6.0 in the given fixed-point format)
package linear_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      MAC   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ACT_IDENT  = 2'd0,
      ACT_RELU   = 2'd1,
      ACT_RELU6  = 2'd2,
      ACT_IDENT3 = 2'd3
   } act_mode_t;

   function automatic int unsigned acc_width(input int unsigned width, input int unsigned n);
      return 2 * width + $clog2(n) + 1;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic longint saturate(input longint x, input int unsigned width);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (width - 1)) - longint'(1);
      lo = -(longint'(1) <<< (width - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic longint activate(input longint x, input act_mode_t mode,
                                       input int unsigned frac);
      longint cap;
      cap = longint'(6) <<< frac;
      case (mode)
         ACT_RELU:  return (x < longint'(0)) ? longint'(0) : x;
         ACT_RELU6: begin
            if (x < longint'(0)) return longint'(0);
            if (x > cap)         return cap;
            return x;
         end
         default:   return x;
      endcase
   endfunction

endpackage

// File: rtl/linear_mac_lane.sv
// One output-feature MAC lane: accumulator with bias preload, and the
// post-processed (shift, saturate, activate) result.
//   clk, rst     : clock, synchronous active-high reset
//   i_preload    : load acc with bias << FRAC
//   i_mac_en     : acc += i_x * i_w
//   i_bias       : bias for this lane's current output feature
//   i_x, i_w     : registered input feature and weight
//   i_act        : activation mode for the frame
//   o_result_c   : post-processed value of the accumulator as it will be
//                  after this cycle (combinational)
module linear_mac_lane
   import linear_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned FRAC  = 8,
   parameter int unsigned ACC_W = acc_width(16, 96)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_preload,
   input  logic                    i_mac_en,
   input  logic signed [WIDTH-1:0] i_bias,
   input  logic signed [WIDTH-1:0] i_x,
   input  logic signed [WIDTH-1:0] i_w,
   input  act_mode_t               i_act,
   output logic signed [WIDTH-1:0] o_result_c
);

   localparam int unsigned PW = 2 * WIDTH;

   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_acc_d;
   logic signed [ACC_W-1:0] w_shift;
   logic signed [PW-1:0]    w_prod;

   // Result is taken from the next accumulator value so the final product
   // is already included on the cycle the lane hands over to drain.
   always_comb begin
      w_prod  = PW'(i_x) * PW'(i_w);
      w_acc_d = r_acc;
      if (i_preload) begin
         w_acc_d = ACC_W'(i_bias) <<< FRAC;
      end else if (i_mac_en) begin
         w_acc_d = r_acc + ACC_W'(w_prod);
      end
      w_shift    = w_acc_d >>> FRAC;
      o_result_c = WIDTH'(activate(saturate(longint'(w_shift), WIDTH), i_act, FRAC));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
      end else begin
         r_acc <= w_acc_d;
      end
   end

endmodule

// File: rtl/linear_par.sv
// Fully connected layer: LANES output features per group computed in
// parallel, ready/valid streaming in and out, weight/bias write ports.
//   clk, rst              : clock, synchronous active-high reset
//   i_act_mode            : activation select, latched on input beat 0
//   i_w_we/addr/data      : weight write, index o*IN_FEATURES+i
//   i_b_we/addr/data      : bias write
//   i_in_valid/o_in_ready : input feature stream, i_in_data, i_in_last
//   o_out_valid/i_out_ready : result stream, o_out_data/idx/last
//   o_busy                : computing or draining
//   o_frame_err           : sticky in_last misplacement flag
//   o_wr_err              : one-cycle pulse for a dropped write
module linear_par
   import linear_pkg::*;
#(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned FRAC         = 8,
   parameter int unsigned IN_FEATURES  = 96,
   parameter int unsigned OUT_FEATURES = 32,
   parameter int unsigned LANES        = 4,
   parameter int unsigned ACC_W        = acc_width(WIDTH, IN_FEATURES)
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [1:0]                                    i_act_mode,
   input  logic                                          i_w_we,
   input  logic [$clog2(OUT_FEATURES*IN_FEATURES)-1:0]   i_w_addr,
   input  logic signed [WIDTH-1:0]                       i_w_data,
   input  logic                                          i_b_we,
   input  logic [$clog2(OUT_FEATURES)-1:0]               i_b_addr,
   input  logic signed [WIDTH-1:0]                       i_b_data,
   input  logic                                          i_in_valid,
   output logic                                          o_in_ready,
   input  logic signed [WIDTH-1:0]                       i_in_data,
   input  logic                                          i_in_last,
   output logic                                          o_out_valid,
   input  logic                                          i_out_ready,
   output logic signed [WIDTH-1:0]                       o_out_data,
   output logic [$clog2(OUT_FEATURES)-1:0]               o_out_idx,
   output logic                                          o_out_last,
   output logic                                          o_busy,
   output logic                                          o_frame_err,
   output logic                                          o_wr_err
);

   localparam int unsigned GROUPS  = OUT_FEATURES / LANES;
   localparam int unsigned W_DEPTH = OUT_FEATURES * IN_FEATURES;
   localparam int unsigned BA_W    = $clog2(OUT_FEATURES);
   localparam int unsigned GRP_W   = idx_width(GROUPS);
   localparam int unsigned LANE_W  = idx_width(LANES);
   localparam int unsigned CNT_W   = $clog2(IN_FEATURES + 1);
   localparam int unsigned IN_W    = idx_width(IN_FEATURES);
   localparam int unsigned ROW_W   = idx_width(GROUPS * IN_FEATURES);

   // Storage: weights banked by o mod LANES so every lane reads each cycle
   logic signed [WIDTH-1:0] r_wmem  [LANES][GROUPS*IN_FEATURES];
   logic signed [WIDTH-1:0] r_bmem  [OUT_FEATURES];
   logic signed [WIDTH-1:0] r_inbuf [IN_FEATURES];
   logic signed [WIDTH-1:0] r_x;
   logic signed [WIDTH-1:0] r_w     [LANES];

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [GRP_W-1:0]   r_grp;
   logic [LANE_W-1:0]  r_lane;
   act_mode_t          r_act;
   logic               r_w_loaded;
   logic               r_b_loaded;

   logic               r_in_ready;
   logic               r_busy;
   logic               r_out_valid;
   logic signed [WIDTH-1:0] r_out_data;
   logic [BA_W-1:0]    r_out_idx;
   logic               r_out_last;
   logic               r_frame_err;
   logic               r_wr_err;

   logic               w_in_fire;
   logic               w_out_fire;
   logic               w_preload;
   logic               w_mac_en;
   logic [IN_W-1:0]    w_rd_i;
   logic [ROW_W-1:0]   w_rd_row;
   logic [LANE_W-1:0]  w_lane_nxt;
   logic [BA_W-1:0]    w_grp_base;
   logic signed [WIDTH-1:0] w_res [LANES];

   int unsigned        w_wa_u;
   int unsigned        w_wo_u;
   int unsigned        w_ba_u;
   logic [LANE_W-1:0]  w_wbank;
   logic [ROW_W-1:0]   w_wrow;
   logic               w_w_ok;
   logic               w_w_drop;
   logic               w_w_final;
   logic               w_b_ok;
   logic               w_b_drop;
   logic               w_b_final;

   assign o_in_ready  = r_in_ready;
   assign o_busy      = r_busy;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_idx   = r_out_idx;
   assign o_out_last  = r_out_last;
   assign o_frame_err = r_frame_err;
   assign o_wr_err    = r_wr_err;

   // Write address decode and acceptance
   always_comb begin
      w_wa_u    = 32'(i_w_addr);
      w_wo_u    = w_wa_u / IN_FEATURES;
      w_ba_u    = 32'(i_b_addr);
      w_wbank   = LANE_W'(w_wo_u % LANES);
      w_wrow    = ROW_W'((w_wo_u / LANES) * IN_FEATURES + (w_wa_u % IN_FEATURES));
      w_w_ok    = i_w_we && !r_busy && (w_wa_u < W_DEPTH);
      w_w_drop  = i_w_we && !w_w_ok;
      w_w_final = (w_wa_u == W_DEPTH - 1);
      w_b_ok    = i_b_we && !r_busy && (w_ba_u < OUT_FEATURES);
      w_b_drop  = i_b_we && !w_b_ok;
      w_b_final = (w_ba_u == OUT_FEATURES - 1);
   end

   // Datapath control decode
   always_comb begin
      w_in_fire  = i_in_valid && r_in_ready;
      w_out_fire = r_out_valid && i_out_ready;
      w_preload  = (r_state == MAC) && (r_cnt == '0);
      w_mac_en   = (r_state == MAC) && (r_cnt != '0);
      w_rd_i     = (r_cnt < CNT_W'(IN_FEATURES)) ? IN_W'(r_cnt) : '0;
      w_rd_row   = ROW_W'(32'(r_grp) * IN_FEATURES + 32'(w_rd_i));
      w_lane_nxt = r_lane + LANE_W'(1);
      w_grp_base = BA_W'(32'(r_grp) * LANES);
   end

   // Memories and one-cycle read pipeline (not reset)
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_inbuf[IN_W'(r_cnt)] <= i_in_data;
      end
      if (w_w_ok) begin
         r_wmem[w_wbank][w_wrow] <= i_w_data;
      end
      if (w_b_ok) begin
         r_bmem[BA_W'(i_b_addr)] <= i_b_data;
      end
      r_x <= r_inbuf[w_rd_i];
      for (int l = 0; l < LANES; l++) begin
         r_w[l] <= r_wmem[l][w_rd_row];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [WIDTH-1:0] w_bias;
      assign w_bias = r_bmem[BA_W'(32'(r_grp) * LANES + l)];

      linear_mac_lane #(
         .WIDTH (WIDTH),
         .FRAC  (FRAC),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .i_preload  (w_preload),
         .i_mac_en   (w_mac_en),
         .i_bias     (w_bias),
         .i_x        (r_x),
         .i_w        (r_w[l]),
         .i_act      (r_act),
         .o_result_c (w_res[l])
      );
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (r_w_loaded && r_b_loaded) w_state_nxt = LOAD;
         end
         LOAD: begin
            if (w_in_fire && (r_cnt == CNT_W'(IN_FEATURES - 1))) w_state_nxt = MAC;
         end
         MAC: begin
            if (r_cnt == CNT_W'(IN_FEATURES)) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_out_fire && (r_lane == LANE_W'(LANES - 1))) begin
               w_state_nxt = (r_grp == GRP_W'(GROUPS - 1)) ? LOAD : MAC;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Counters, flags and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_grp       <= '0;
         r_lane      <= '0;
         r_act       <= ACT_IDENT;
         r_w_loaded  <= 1'b0;
         r_b_loaded  <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
         r_frame_err <= 1'b0;
         r_wr_err    <= 1'b0;
      end else begin
         r_in_ready <= (w_state_nxt == LOAD);
         r_busy     <= (w_state_nxt == MAC) || (w_state_nxt == DRAIN);
         r_wr_err   <= w_w_drop || w_b_drop;
         if (w_w_ok && w_w_final) r_w_loaded <= 1'b1;
         if (w_b_ok && w_b_final) r_b_loaded <= 1'b1;

         case (r_state)
            LOAD: begin
               if (w_in_fire) begin
                  if (r_cnt == '0) r_act <= act_mode_t'(i_act_mode);
                  // Frame length is fixed; in_last only serves as a check
                  if (r_cnt == CNT_W'(IN_FEATURES - 1)) begin
                     if (!i_in_last) r_frame_err <= 1'b1;
                     r_cnt <= '0;
                     r_grp <= '0;
                  end else begin
                     if (i_in_last) r_frame_err <= 1'b1;
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            MAC: begin
               if (r_cnt == CNT_W'(IN_FEATURES)) begin
                  r_cnt       <= '0;
                  r_lane      <= '0;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_res[0];
                  r_out_idx   <= w_grp_base;
                  r_out_last  <= (w_grp_base == BA_W'(OUT_FEATURES - 1));
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (w_out_fire) begin
                  if (r_lane == LANE_W'(LANES - 1)) begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     if (r_grp != GRP_W'(GROUPS - 1)) r_grp <= r_grp + GRP_W'(1);
                  end else begin
                     r_lane     <= w_lane_nxt;
                     r_out_data <= w_res[w_lane_nxt];
                     r_out_idx  <= r_out_idx + BA_W'(1);
                     r_out_last <= ((r_out_idx + BA_W'(1)) == BA_W'(OUT_FEATURES - 1));
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_linear_par.sv
// Scoreboard bench for linear_par with IN=4, OUT=4, LANES=2, Q8.8 data.
module tb_linear_par;

   localparam int IN_F  = 4;
   localparam int OUT_F = 4;

   typedef struct {
      logic signed [15:0] data;
      logic [1:0]         idx;
      logic               last;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [1:0]         act_mode = 2'd0;
   logic               w_we = 1'b0;
   logic [3:0]         w_addr = '0;
   logic signed [15:0] w_data = '0;
   logic               b_we = 1'b0;
   logic [1:0]         b_addr = '0;
   logic signed [15:0] b_data = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_data = '0;
   logic               in_last = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [15:0] out_data;
   logic [1:0]         out_idx;
   logic               out_last;
   logic               busy;
   logic               frame_err;
   logic               wr_err;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic stall_armed = 1'b0;
   logic stall_done  = 1'b0;

   linear_par #(
      .WIDTH        (16),
      .FRAC         (8),
      .IN_FEATURES  (IN_F),
      .OUT_FEATURES (OUT_F),
      .LANES        (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_act_mode  (act_mode),
      .i_w_we      (w_we),
      .i_w_addr    (w_addr),
      .i_w_data    (w_data),
      .i_b_we      (b_we),
      .i_b_addr    (b_addr),
      .i_b_data    (b_data),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (in_data),
      .i_in_last   (in_last),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_idx   (out_idx),
      .o_out_last  (out_last),
      .o_busy      (busy),
      .o_frame_err (frame_err),
      .o_wr_err    (wr_err)
   );

   always #5 clk = ~clk;

   // Monitor: every valid cycle is compared with the queue head, which
   // also checks that a stalled beat holds its value; pop on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL out_unexpected: got data=%0d idx=%0d, want nothing", out_data, out_idx);
         end else begin
            if (out_data !== q[0].data || out_idx !== q[0].idx || out_last !== q[0].last) begin
               n_bad++;
               $display("FAIL out_beat: got data=%0d idx=%0d last=%0b, want data=%0d idx=%0d last=%0b",
                        out_data, out_idx, out_last, q[0].data, q[0].idx, q[0].last);
            end
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   // Backpressure: hold out_ready low for 5 cycles once idx 1 is presented
   always @(posedge clk) begin
      #1;
      if (stall_armed && !stall_done && out_valid && out_idx == 2'd1) begin
         out_ready = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         out_ready  = 1'b1;
         stall_done = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic load_weights(input logic signed [15:0] wv);
      for (int a = 0; a < OUT_F * IN_F; a++) begin
         w_we   = 1'b1;
         w_addr = 4'(a);
         w_data = wv;
         tick();
      end
      w_we = 1'b0;
   endtask

   task automatic load_biases(input logic signed [15:0] b0, input logic signed [15:0] b1,
                              input logic signed [15:0] b2, input logic signed [15:0] b3);
      logic signed [15:0] bs [4];
      bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
      for (int a = 0; a < OUT_F; a++) begin
         b_we   = 1'b1;
         b_addr = 2'(a);
         b_data = bs[a];
         tick();
      end
      b_we = 1'b0;
   endtask

   task automatic push4(input logic signed [15:0] d0, input logic signed [15:0] d1,
                        input logic signed [15:0] d2, input logic signed [15:0] d3);
      exp_t e;
      logic signed [15:0] ds [4];
      ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
      for (int i = 0; i < 4; i++) begin
         e.data = ds[i];
         e.idx  = 2'(i);
         e.last = (i == OUT_F - 1);
         q.push_back(e);
      end
   endtask

   task automatic send_frame(input logic signed [15:0] x0, input logic signed [15:0] x1,
                             input logic signed [15:0] x2, input logic signed [15:0] x3,
                             input logic [1:0] mode, input logic [3:0] lmask);
      logic signed [15:0] xs [4];
      logic acc;
      int   guard;
      xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
      act_mode = mode;
      for (int b = 0; b < IN_F; b++) begin
         in_valid = 1'b1;
         in_data  = xs[b];
         in_last  = lmask[b];
         acc      = 1'b0;
         guard    = 0;
         while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
         end
         if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_accept_timeout: got no in_ready on beat %0d, want accept", b);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_empty();
      int g;
      g = 0;
      while ((q.size() != 0 || out_valid) && g < 400) begin
         tick();
         g++;
      end
      if (q.size() != 0 || out_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d beats pending, want 0", q.size());
      end
   endtask

   initial begin
      int n;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_in_ready",  in_ready,  0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy",      busy,      0);
      check("rst_frame_err", frame_err, 0);
      check("rst_wr_err",    wr_err,    0);
      check("rst_out_data",  out_data,  0);
      check("rst_out_idx",   out_idx,   0);
      check("rst_out_last",  out_last,  0);

      // Basic dot product: 256*(256+512+768+1024) >> 8 = 2560
      load_weights(16'sd256);
      load_biases(16'sd0, 16'sd0, 16'sd0, 16'sd0);
      push4(16'sd2560, 16'sd2560, 16'sd2560, 16'sd2560);
      send_frame(16'sd256, 16'sd512, 16'sd768, 16'sd1024, 2'd0, 4'b1000);
      // out_valid visible in the cycle IN+2 after the last beat's cycle
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check("latency_edges", n, IN_F + 1);
      wait_empty();
      check("frame_err_clean", frame_err, 0);

      // Backpressure on idx 1
      stall_armed = 1'b1;
      push4(16'sd2560, 16'sd2560, 16'sd2560, 16'sd2560);
      send_frame(16'sd256, 16'sd512, 16'sd768, 16'sd1024, 2'd0, 4'b1000);
      wait_empty();
      stall_armed = 1'b0;
      check("stall_seen", stall_done, 1);

      // Positive and negative saturation
      load_weights(16'sd32512);
      push4(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
      send_frame(16'sd32512, 16'sd32512, 16'sd32512, 16'sd32512, 2'd0, 4'b1000);
      wait_empty();
      load_weights(-16'sd32512);
      push4(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
      send_frame(16'sd32512, 16'sd32512, 16'sd32512, 16'sd32512, 2'd0, 4'b1000);
      wait_empty();

      // Bias only, all activation modes
      load_weights(16'sd0);
      load_biases(-16'sd512, 16'sd2560, 16'sd0, 16'sd0);
      push4(16'sd0, 16'sd2560, 16'sd0, 16'sd0);
      send_frame(16'sd100, 16'sd200, 16'sd300, 16'sd400, 2'd1, 4'b1000);
      wait_empty();
      push4(16'sd0, 16'sd1536, 16'sd0, 16'sd0);
      send_frame(16'sd100, 16'sd200, 16'sd300, 16'sd400, 2'd2, 4'b1000);
      wait_empty();
      push4(-16'sd512, 16'sd2560, 16'sd0, 16'sd0);
      send_frame(16'sd100, 16'sd200, 16'sd300, 16'sd400, 2'd0, 4'b1000);
      wait_empty();
      push4(-16'sd512, 16'sd2560, 16'sd0, 16'sd0);
      send_frame(16'sd100, 16'sd200, 16'sd300, 16'sd400, 2'd3, 4'b1000);
      wait_empty();

      // Misplaced in_last, then a write while busy
      load_weights(16'sd256);
      load_biases(16'sd0, 16'sd0, 16'sd0, 16'sd0);
      push4(16'sd2560, 16'sd2560, 16'sd2560, 16'sd2560);
      send_frame(16'sd256, 16'sd512, 16'sd768, 16'sd1024, 2'd0, 4'b1010);
      check("frame_err_set", frame_err, 1);
      check("busy_in_mac", busy, 1);
      w_we   = 1'b1;
      w_addr = 4'd0;
      w_data = 16'sd999;
      tick();
      w_we = 1'b0;
      check("wr_err_pulse", wr_err, 1);
      tick();
      check("wr_err_clear", wr_err, 0);
      wait_empty();
      push4(16'sd2560, 16'sd2560, 16'sd2560, 16'sd2560);
      send_frame(16'sd256, 16'sd512, 16'sd768, 16'sd1024, 2'd0, 4'b1000);
      wait_empty();
      check("frame_err_sticky", frame_err, 1);

      // Reset mid-MAC
      push4(16'sd2560, 16'sd2560, 16'sd2560, 16'sd2560);
      send_frame(16'sd256, 16'sd512, 16'sd768, 16'sd1024, 2'd0, 4'b1000);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("mrst_in_ready",  in_ready,  0);
      check("mrst_out_valid", out_valid, 0);
      check("mrst_busy",      busy,      0);
      check("mrst_frame_err", frame_err, 0);
      check("mrst_out_data",  out_data,  0);
      check("mrst_out_idx",   out_idx,   0);
      check("mrst_out_last",  out_last,  0);
      q.delete();
      rst = 1'b0;
      repeat (3) tick();
      check("mrst_no_ready", in_ready, 0);
      load_weights(16'sd256);
      repeat (3) tick();
      check("mrst_w_only", in_ready, 0);
      load_biases(16'sd0, 16'sd0, 16'sd0, 16'sd0);
      n = 0;
      while (!in_ready && n < 10) begin
         tick();
         n++;
      end
      check("mrst_reload_ready", in_ready, 1);
      push4(16'sd2560, 16'sd2560, 16'sd2560, 16'sd2560);
      send_frame(16'sd256, 16'sd512, 16'sd768, 16'sd1024, 2'd0, 4'b1000);
      wait_empty();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
